// File: rtl/ide_pio_sequencer.sv
// IDE PIO cycle sequencer: programmable setup/strobe/recovery timing with IORDY
// wait, IORDY timeout bus error and enforced recovery between accesses.
module ide_pio_sequencer #(
  parameter int unsigned SETUP_DEF  = 2,
  parameter int unsigned STROBE_DEF = 3,
  parameter int unsigned RECOV_DEF  = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic        cycReq,
  input  logic        rnw,
  input  logic        regSel,
  input  logic        ioRdy,
  input  logic        cfgWr,
  input  logic [11:0] cfgData,
  output logic        nIdeCS1,
  output logic        nIdeCS3,
  output logic        nIORd,
  output logic        nIOWr,
  output logic        nIdeBufEn,
  output logic        dsack16,
  output logic        berr,
  output logic        busy,
  output logic [11:0] cfgOut
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [11:0] CFG_RST = {4'(RECOV_DEF), 4'(STROBE_DEF), 4'(SETUP_DEF)};

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAITRDY, ACK, HOLD, RECOV
  } state_t;

  state_t              state, state_nxt;
  logic [11:0]         cfg;
  logic [3:0]          strobe_sh, recov_sh;
  logic                rnw_lat, sel_lat;
  logic [3:0]          cnt, cnt_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic                cs_on, strb_on, dsack_nxt, berr_nxt, sel_now;

  // A zero field behaves as one cycle; the counter holds (cycles - 1).
  function automatic logic [3:0] phase_load(input logic [3:0] f);
    return (f == 4'd0) ? 4'd0 : f - 4'd1;
  endfunction

  assign cfgOut  = cfg;
  assign sel_now = (state == IDLE) ? regSel : sel_lat;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wcnt_nxt  = wcnt;
    cs_on     = 1'b0;
    strb_on   = 1'b0;
    dsack_nxt = 1'b0;
    berr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cycReq) begin
          state_nxt = SETUP;
          cnt_nxt   = phase_load(cfg[3:0]);
          cs_on     = 1'b1;
        end
      end
      SETUP: begin
        if (!cycReq) begin
          state_nxt = RECOV;
          cnt_nxt   = phase_load(recov_sh);
        end else if (cnt == 4'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = phase_load(strobe_sh);
          cs_on     = 1'b1;
          strb_on   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
          cs_on   = 1'b1;
        end
      end
      STROBE: begin
        if (!cycReq) begin
          state_nxt = RECOV;
          cnt_nxt   = phase_load(recov_sh);
        end else if (cnt == 4'd0) begin
          cs_on = 1'b1;
          if (ioRdy) begin
            state_nxt = ACK;
            dsack_nxt = 1'b1;
          end else begin
            state_nxt = WAITRDY;
            wcnt_nxt  = '0;
            strb_on   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
          cs_on   = 1'b1;
          strb_on = 1'b1;
        end
      end
      WAITRDY: begin
        // IORDY wins over the timeout on the final waiting edge.
        if (!cycReq) begin
          state_nxt = RECOV;
          cnt_nxt   = phase_load(recov_sh);
        end else if (ioRdy) begin
          state_nxt = ACK;
          cs_on     = 1'b1;
          dsack_nxt = 1'b1;
        end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
          state_nxt = HOLD;
          cs_on     = 1'b1;
          berr_nxt  = 1'b1;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
          cs_on    = 1'b1;
          strb_on  = 1'b1;
        end
      end
      ACK: begin
        if (!cycReq) begin
          state_nxt = RECOV;
          cnt_nxt   = phase_load(recov_sh);
        end else begin
          state_nxt = HOLD;
          cs_on     = 1'b1;
          dsack_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (!cycReq) begin
          state_nxt = RECOV;
          cnt_nxt   = phase_load(recov_sh);
        end else begin
          cs_on     = 1'b1;
          dsack_nxt = dsack16;
          berr_nxt  = berr;
        end
      end
      RECOV: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state     <= IDLE;
      cfg       <= CFG_RST;
      nIdeCS1   <= 1'b1;
      nIdeCS3   <= 1'b1;
      nIORd     <= 1'b1;
      nIOWr     <= 1'b1;
      nIdeBufEn <= 1'b1;
      dsack16   <= 1'b0;
      berr      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (cfgWr) cfg <= cfgData;
      nIdeCS1   <= !(cs_on && !sel_now);
      nIdeCS3   <= !(cs_on && sel_now);
      nIORd     <= !(strb_on && rnw_lat);
      nIOWr     <= !(strb_on && !rnw_lat);
      nIdeBufEn <= !cs_on;
      dsack16   <= dsack_nxt;
      berr      <= berr_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Cycle attributes and shadow timings frozen at the IDLE->SETUP edge.
  always_ff @(posedge sysClk) begin
    cnt  <= cnt_nxt;
    wcnt <= wcnt_nxt;
    if (state == IDLE && cycReq) begin
      rnw_lat   <= rnw;
      sel_lat   <= regSel;
      strobe_sh <= cfg[7:4];
      recov_sh  <= cfg[11:8];
    end
  end

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Scoreboard bench for ide_pio_sequencer: a CPU-like driver predicts each cycle's
// timing from the timing rules, a monitor measures the pin waveforms and compares.
module tb_ide_pio_sequencer;

  localparam int TIMEOUT = 64;
  localparam logic [11:0] CFG_DEF = 12'h232;

  logic        sysClk = 1'b0;
  logic        reset, cycReq, rnw, regSel, ioRdy, cfgWr;
  logic [11:0] cfgData;
  logic        nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn, dsack16, berr, busy;
  logic [11:0] cfgOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sel;    // 0 = CS1, 1 = CS3
    int kind;   // 0 = no strobe, 1 = read strobe, 2 = write strobe
    int len;    // cycles CS low
    int setup;  // cycles CS low before strobe
    int strb;   // cycles strobe low
    int ack;    // cycles dsack16 high
    int berr;   // cycles berr high
    int gap;    // cycles CS high before this cycle, -1 = unknown
  } exp_t;

  exp_t        q[$];
  int          rdy_n = 0;
  logic [11:0] cfg_m;
  int          prev_r;
  bit          first;

  ide_pio_sequencer #(
    .SETUP_DEF(2), .STROBE_DEF(3), .RECOV_DEF(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .sysClk(sysClk), .reset(reset), .cycReq(cycReq), .rnw(rnw), .regSel(regSel),
    .ioRdy(ioRdy), .cfgWr(cfgWr), .cfgData(cfgData),
    .nIdeCS1(nIdeCS1), .nIdeCS3(nIdeCS3), .nIORd(nIORd), .nIOWr(nIOWr),
    .nIdeBufEn(nIdeBufEn), .dsack16(dsack16), .berr(berr), .busy(busy),
    .cfgOut(cfgOut)
  );

  always #5 sysClk = ~sysClk;

  function automatic int eff(input int f);
    return (f == 0) ? 1 : f;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive model: IORDY stays low until the strobe has been low rdy_n cycles.
  initial begin : drive_model
    int c;
    c = 0;
    ioRdy = 1'b1;
    forever begin
      @(negedge sysClk);
      if (!nIORd || !nIOWr) c++;
      else                  c = 0;
      ioRdy = (c >= rdy_n);
    end
  end

  initial begin : monitor
    bit   in_cyc, cs_low, strb_low, inv, m_rd, m_wr;
    int   gap_cnt, m_gap, m_sel, m_len, m_setup, m_strb, m_ack, m_berr;
    exp_t e;
    in_cyc = 0; gap_cnt = 0;
    m_gap = 0; m_sel = 0; m_len = 0; m_setup = 0; m_strb = 0; m_ack = 0; m_berr = 0;
    m_rd = 0; m_wr = 0;
    forever begin
      @(negedge sysClk);
      cs_low   = !nIdeCS1 || !nIdeCS3;
      strb_low = !nIORd || !nIOWr;
      inv = (nIdeCS1 || nIdeCS3) && (nIORd || nIOWr) && !(strb_low && !cs_low) &&
            !(dsack16 && berr) && (nIdeBufEn == !cs_low) && (!cs_low || busy);
      chk("invariants", int'(inv), 1);
      if (cs_low) begin
        if (!in_cyc) begin
          in_cyc = 1; m_gap = gap_cnt; m_sel = !nIdeCS3 ? 1 : 0;
          m_len = 0; m_setup = 0; m_strb = 0; m_ack = 0; m_berr = 0; m_rd = 0; m_wr = 0;
        end
        m_len++;
        if (strb_low) begin
          m_strb++;
          if (!nIORd) m_rd = 1;
          if (!nIOWr) m_wr = 1;
        end else if (m_strb == 0) m_setup++;
        if (dsack16) m_ack++;
        if (berr)    m_berr++;
      end else begin
        if (in_cyc) begin
          in_cyc = 0;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cycle: got a CS cycle of %0d, expected none", m_len);
          end else begin
            e = q.pop_front();
            chk("cs_select", m_sel, e.sel);
            chk("strobe_kind", (m_rd ? 1 : 0) + (m_wr ? 2 : 0), e.kind);
            chk("cs_length", m_len, e.len);
            chk("setup_cycles", m_setup, e.setup);
            chk("strobe_cycles", m_strb, e.strb);
            chk("dsack_cycles", m_ack, e.ack);
            chk("berr_cycles", m_berr, e.berr);
            if (e.gap >= 0) chk("recovery_gap", m_gap, e.gap);
          end
          gap_cnt = 0;
        end
        gap_cnt++;
      end
    end
  end

  // abort_a: -1 none, -2 random point before acknowledge, >=0 fixed cycles after CS.
  task automatic txn(input bit rd, input bit sel, input int n, input int abort_a,
                     input int hold, input int gap, input bit pre_wr, input logic [11:0] pre_v,
                     input bit mid_wr, input logic [11:0] mid_v, input bit do_reset);
    exp_t e;
    int s, t, r, w, a, k;
    bit bcase;
    a = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge sysClk);
      cfgWr = 1'b0;
      if (i == 0 && pre_wr && gap >= 2) begin
        cfgWr = 1'b1; cfgData = pre_v; cfg_m = pre_v;
      end
    end
    chk("cfg_readback", int'(cfgOut), int'(cfg_m));
    s = eff(int'(cfg_m[3:0]));
    t = eff(int'(cfg_m[7:4]));
    r = eff(int'(cfg_m[11:8]));
    if (n <= t)                w = t;
    else if (n <= t + TIMEOUT) w = n;
    else                       w = t + TIMEOUT;
    bcase = (n > t + TIMEOUT);
    e.sel  = sel ? 1 : 0;
    e.kind = rd ? 1 : 2;
    e.gap  = first ? -1 : ((prev_r + 1 > gap) ? prev_r + 1 : gap);
    if (do_reset) begin
      e.len = s + 1; e.setup = s; e.strb = 1; e.ack = 0; e.berr = 0;
    end else if (abort_a != -1) begin
      a = (abort_a < 0) ? int'($urandom_range(0, s + w - 1)) : abort_a;
      e.len   = a + 1;
      e.setup = (a + 1 < s) ? a + 1 : s;
      e.strb  = (a + 1 > s) ? a + 1 - s : 0;
      e.ack = 0; e.berr = 0;
    end else begin
      e.len = s + w + hold + 1; e.setup = s; e.strb = w;
      e.ack  = bcase ? 0 : hold + 1;
      e.berr = bcase ? hold + 1 : 0;
    end
    if (e.strb == 0) e.kind = 0;
    q.push_back(e);

    rdy_n = n; rnw = rd; regSel = sel; cycReq = 1'b1;
    k = 0;
    while (nIdeCS1 && nIdeCS3 && k < 100) begin
      @(negedge sysClk); k++;
    end
    if (k >= 100) begin
      checks++; errors++;
      $display("FAIL cs_assert_timeout: got no CS after %0d cycles, expected CS", k);
      void'(q.pop_back());
      cycReq = 1'b0;
      return;
    end
    if (mid_wr) begin
      cfgWr = 1'b1; cfgData = mid_v; cfg_m = mid_v;
    end
    if (do_reset) begin
      k = 0;
      while (nIORd && nIOWr && k < 100) begin
        @(negedge sysClk); cfgWr = 1'b0; k++;
      end
      reset = 1'b1; cycReq = 1'b0;
      @(negedge sysClk);
      reset = 1'b0; cfgWr = 1'b0;
      chk("reset_mid_outputs", int'({nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn, dsack16, berr, busy}), 'hF8);
      chk("reset_mid_cfg", int'(cfgOut), int'(CFG_DEF));
      cfg_m = CFG_DEF;
      first = 1;
    end else if (abort_a != -1) begin
      repeat (a) begin
        @(negedge sysClk); cfgWr = 1'b0;
      end
      cycReq = 1'b0;
      prev_r = r; first = 0;
    end else begin
      k = 0;
      while (!(dsack16 || berr) && k < 200) begin
        @(negedge sysClk); cfgWr = 1'b0; k++;
      end
      if (k >= 200) begin
        checks++; errors++;
        $display("FAIL ack_timeout: got no dsack16/berr after %0d cycles, expected one", k);
      end
      repeat (hold) begin
        @(negedge sysClk); cfgWr = 1'b0;
      end
      cycReq = 1'b0;
      prev_r = r; first = 0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [11:0] v, mv;
    int g, ab, nn;
    bit pw, mw;
    reset = 1'b1; cycReq = 1'b0; rnw = 1'b1; regSel = 1'b0;
    cfgWr = 1'b0; cfgData = '0;
    cfg_m = CFG_DEF; first = 1; prev_r = 0;
    repeat (3) @(negedge sysClk);
    chk("reset_outputs", int'({nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn, dsack16, berr, busy}), 'hF8);
    chk("reset_cfg", int'(cfgOut), int'(CFG_DEF));
    reset = 1'b0;

    // Directed scenarios: defaults, reprogrammed write, IORDY stretch, timeout,
    // back-to-back with mid-cycle reconfig, reset in strobe, abort in setup.
    txn(1, 0, 0,   -1, 2, 2, 0, 12'h000, 0, 12'h000, 0);
    txn(0, 1, 0,   -1, 1, 3, 1, 12'h514, 0, 12'h000, 0);
    txn(1, 0, 0,   -1, 0, 1, 0, 12'h000, 0, 12'h000, 0);
    txn(1, 0, 13,  -1, 1, 3, 1, 12'h232, 0, 12'h000, 0);
    txn(1, 0, 255, -1, 2, 2, 0, 12'h000, 0, 12'h000, 0);
    txn(0, 1, 0,   -1, 0, 1, 0, 12'h000, 1, 12'h341, 0);
    txn(1, 0, 0,   -1, 1, 1, 0, 12'h000, 0, 12'h000, 0);
    txn(1, 0, 255, -1, 0, 2, 0, 12'h000, 0, 12'h000, 1);
    txn(1, 1, 0,    0, 0, 2, 0, 12'h000, 0, 12'h000, 0);
    txn(0, 0, 20,  -2, 0, 1, 1, 12'h000, 0, 12'h000, 0);

    for (int i = 0; i < 60; i++) begin
      v  = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
      mv = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
      pw = ($urandom_range(0, 3) == 0);
      mw = ($urandom_range(0, 3) == 0);
      g  = $urandom_range(1, 8);
      if (pw && g < 2) g = 2;
      ab = ($urandom_range(0, 4) == 0) ? -2 : -1;
      nn = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 20));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nn, ab,
          $urandom_range(0, 3), g, pw, v, mw, mv, 0);
    end

    repeat (6) begin
      @(negedge sysClk); cfgWr = 1'b0;
    end
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
